// File: rtl/key_tick_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : key_tick_gen_if
// Purpose  : Groups the pushbutton/run inputs and the counter-control outputs
//            of key_tick_gen into one bundle.
// Signals  : key_n     - raw active-low pushbutton (asynchronous, bouncing)
//            run_en    - synchronous tick-generation enable
//            tick      - one-cycle count-enable pulse
//            clr_n     - debounced active-low clear level
//            clr_pulse - one-cycle pulse per accepted press
// Modports : master - drives key_n/run_en (stimulus side)
//            slave  - the key_tick_gen block
// Revision : 1.0 - initial release
// ============================================================================
interface key_tick_gen_if;
  logic key_n;
  logic run_en;
  logic tick;
  logic clr_n;
  logic clr_pulse;

  modport master (
    output key_n,
    output run_en,
    input  tick,
    input  clr_n,
    input  clr_pulse
  );

  modport slave (
    input  key_n,
    input  run_en,
    output tick,
    output clr_n,
    output clr_pulse
  );
endinterface
`default_nettype wire

// File: rtl/key_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : key_tick_gen
// Purpose  : Debounces an active-low pushbutton into a clear level/pulse and
//            generates a periodic single-cycle count-enable tick, both in the
//            clk_50mhz domain, for a downstream 2-bit counter.
// Ports    : clk_50mhz - system clock, rising edge
//            rst_50mhz - asynchronous active-low reset
//            bus       - key_tick_gen_if.slave (key_n, run_en in;
//                        tick, clr_n, clr_pulse out)
// Params   : CLK_DIV      - clock cycles per tick period (>= 2)
//            DEBOUNCE_CYC - stable cycles needed to accept a change (>= 2)
// Revision : 1.0 - initial release
// ============================================================================
module key_tick_gen #(
  parameter int CLK_DIV      = 50000000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  wire logic      clk_50mhz,
  input  wire logic      rst_50mhz,
  key_tick_gen_if.slave  bus
);

  localparam int c_DEB_W = $clog2(DEBOUNCE_CYC);
  localparam int c_DIV_W = $clog2(CLK_DIV);

  localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [c_DEB_W-1:0] c_DEB_ONE  = c_DEB_W'(1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  logic               r_sync1_n;
  logic               r_sync_n;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_DEB_W-1:0] r_deb_cnt;
  logic [c_DEB_W-1:0] w_deb_cnt_nxt;
  logic               w_accept;
  logic [c_DIV_W-1:0] r_div_cnt;
  logic               r_tick;
  logic               r_clr_n;
  logic               r_clr_pulse;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk_50mhz or negedge rst_50mhz) begin
    if (!rst_50mhz) begin
      r_sync1_n <= 1'b1;
      r_sync_n  <= 1'b1;
    end else begin
      r_sync1_n <= bus.key_n;
      r_sync_n  <= r_sync1_n;
    end
  end

  // Debounce FSM state register.
  always_ff @(posedge clk_50mhz or negedge rst_50mhz) begin
    if (!rst_50mhz) begin
      r_state   <= RELEASED;
      r_deb_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_deb_cnt_nxt;
    end
  end

  // Debounce FSM next-state logic. w_accept marks the PRESS_CHK->PRESSED edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_deb_cnt_nxt = r_deb_cnt;
    w_accept      = 1'b0;
    case (r_state)
      RELEASED: begin
        if (!r_sync_n) begin
          w_state_nxt   = PRESS_CHK;
          w_deb_cnt_nxt = '0;
        end
      end
      PRESS_CHK: begin
        if (r_sync_n) begin
          w_state_nxt = RELEASED;
        end else if (r_deb_cnt == c_DEB_LAST) begin
          w_state_nxt = PRESSED;
          w_accept    = 1'b1;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + c_DEB_ONE;
        end
      end
      PRESSED: begin
        if (r_sync_n) begin
          w_state_nxt   = RELEASE_CHK;
          w_deb_cnt_nxt = '0;
        end
      end
      RELEASE_CHK: begin
        if (!r_sync_n) begin
          w_state_nxt = PRESSED;
        end else if (r_deb_cnt == c_DEB_LAST) begin
          w_state_nxt = RELEASED;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + c_DEB_ONE;
        end
      end
      default: begin
        w_state_nxt   = RELEASED;
        w_deb_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs registered from the next state so clr_n changes on the same edge
  // the FSM enters/leaves the pressed half of the state space.
  always_ff @(posedge clk_50mhz or negedge rst_50mhz) begin
    if (!rst_50mhz) begin
      r_clr_n     <= 1'b1;
      r_clr_pulse <= 1'b0;
    end else begin
      r_clr_n     <= !((w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_CHK));
      r_clr_pulse <= w_accept;
    end
  end

  // Tick divider. An accepted press restarts the period and suppresses any
  // wrap on that edge, so a tick never coincides with clr_pulse.
  always_ff @(posedge clk_50mhz or negedge rst_50mhz) begin
    if (!rst_50mhz) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (w_accept) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (bus.run_en) begin
      if (r_div_cnt == c_DIV_LAST) begin
        r_div_cnt <= '0;
        r_tick    <= 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + c_DIV_ONE;
        r_tick    <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign bus.tick      = r_tick;
  assign bus.clr_n     = r_clr_n;
  assign bus.clr_pulse = r_clr_pulse;

endmodule
`default_nettype wire

// File: doc/key_tick_gen.md
KEY_TICK_GEN -- requirements
Module: key_tick_gen

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 50000000, meaning clk_50mhz cycles per tick period (legal range >= 2).
REQ-002 The module SHALL have parameter DEBOUNCE_CYC, default 1000000 (20 ms), meaning the stable-level cycles required to accept a key change (legal range >= 2).
REQ-003 The module SHALL have port clk_50mhz, input, 1 bit: system clock; all state SHALL be updated on its rising edge.
REQ-004 The module SHALL have port rst_50mhz, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port key_n, input, 1 bit: raw pushbutton, active-low, asynchronous to clk_50mhz and bouncing.
REQ-006 The module SHALL have port run_en, input, 1 bit, synchronous: enables tick generation.
REQ-007 The module SHALL have port tick, output, 1 bit: one-cycle count-enable pulse for the downstream 2-bit counter.
REQ-008 The module SHALL have port clr_n, output, 1 bit: debounced clear level, active-low, for the downstream counter.
REQ-009 The module SHALL have port clr_pulse, output, 1 bit: one-cycle pulse on each accepted press.

Function
REQ-010 key_n SHALL pass through a 2-flop synchronizer; only the second flop output (sync_n) SHALL be used by the logic below.
REQ-011 Debounce FSM states SHALL be RELEASED, PRESS_CHK, PRESSED and RELEASE_CHK, using a counter deb_cnt sized by ceil(log2(DEBOUNCE_CYC)).
REQ-012 In RELEASED, sync_n=0 SHALL cause a move to PRESS_CHK with deb_cnt<=0; otherwise the FSM SHALL hold.
REQ-013 In PRESS_CHK:
- sync_n=1 SHALL cause a return to RELEASED (bounce rejected).
- Else, deb_cnt==DEBOUNCE_CYC-1 SHALL cause a move to PRESSED.
- Else, deb_cnt SHALL increment.
REQ-014 In PRESSED, sync_n=1 SHALL cause a move to RELEASE_CHK with deb_cnt<=0; otherwise the FSM SHALL hold.
REQ-015 In RELEASE_CHK:
- sync_n=0 SHALL cause a return to PRESSED.
- Else, deb_cnt==DEBOUNCE_CYC-1 SHALL cause a move to RELEASED.
- Else, deb_cnt SHALL increment.
REQ-016 clr_n SHALL be registered and SHALL be 0 whenever the state is PRESSED or RELEASE_CHK, and 1 otherwise.
REQ-017 Latency: with key_n held stably low, clr_n SHALL fall after rising edge DEBOUNCE_CYC+3, counted from the first edge that samples key_n=0.
REQ-018 Release SHALL be symmetric: clr_n SHALL rise after edge DEBOUNCE_CYC+3 of stable key_n=1.
REQ-019 clr_pulse SHALL be 1 for exactly the one cycle following the PRESS_CHK->PRESSED edge; no pulse SHALL be generated on release or on RELEASE_CHK->PRESSED.
REQ-020 The tick divider div_cnt SHALL be sized by ceil(log2(CLK_DIV)) and SHALL count 0..CLK_DIV-1, then wrap to 0.
REQ-021 Divider rules on each edge:
- If run_en=1 and div_cnt==CLK_DIV-1: div_cnt<=0 and tick<=1.
- If run_en=1 otherwise: div_cnt increments and tick<=0.
- If run_en=0: div_cnt holds and tick<=0.
REQ-022 With run_en held at 1, tick SHALL be a registered single-cycle pulse with period exactly CLK_DIV cycles.
REQ-023 Simultaneous events: on the PRESS_CHK->PRESSED edge, div_cnt<=0 and tick<=0 SHALL take priority over the wrap, so no tick coincides with clr_pulse.
REQ-024 While clr_n=0, the divider SHALL run normally; the downstream counter ignores ticks through its clear.
REQ-025 Deasserting run_en mid-period SHALL freeze div_cnt; reasserting it SHALL resume counting from the frozen value.
REQ-026 No derived or gated clock SHALL be produced; tick is an enable in the clk_50mhz domain.

Reset
REQ-027 rst_50mhz=0 SHALL immediately force the synchronizer flops to 1, FSM=RELEASED, deb_cnt=0, div_cnt=0, tick=0, clr_n=1 and clr_pulse=0.
REQ-028 Reset asserted mid-debounce or mid-period SHALL discard all progress; after reset release, a held key SHALL need the full DEBOUNCE_CYC+3 edges.
REQ-029 Reset deassertion SHALL be synchronized externally; no output SHALL glitch on the release edge.

Verification (CLK_DIV=10, DEBOUNCE_CYC=4)
REQ-030 Scenario: run_en=1 from reset, key idle -> tick high after edges 10, 20, 30, each high one cycle; clr_n=1 throughout.
REQ-031 Scenario: key_n low held -> clr_n falls after edge 7; clr_pulse high one cycle after edge 7; div_cnt=0 after edge 7 and tick=0.
REQ-032 Scenario: key_n toggled with pulses of 3 low cycles / 1 high cycle -> clr_n stays 1 and clr_pulse never asserts.
REQ-033 Scenario: press accepted, then release with a 2-cycle high bounce -> clr_n stays 0; a stable release gives clr_n=1 seven edges after the last rising key_n edge; no clr_pulse on release.
REQ-034 Scenario: run_en dropped at div_cnt=5 for 20 cycles, then restored -> next tick 5 edges after restore.
REQ-035 Scenario: rst_50mhz pulsed low while in PRESS_CHK with deb_cnt=2 -> all outputs reset at once; with key still low, clr_n falls 7 edges after reset release.
